osnt_inter_packet_delay_recorder: RTL and testbench

Receive-side counterpart of the TX inter-packet delay block. It sits in the monitor path after the RX queues. It measures the gap, in axis_aclk cycles, between the start-of-packet acceptances of consecutive packets. It writes that gap into the tuser delay field of each packet's first beat, in the same field position the TX delay block consumes, so a captured stream can be replayed with its original spacing. It also exports last/max delay and a packet count for the register block.

---
 rtl/osnt_ipd_pkg.sv | 16 +
 rtl/osnt_inter_packet_delay_recorder_gap_meter.sv | 71 +++++++
 rtl/osnt_inter_packet_delay_recorder.sv | 127 ++++++++++++
 tb/tb_osnt_inter_packet_delay_recorder.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/osnt_ipd_pkg.sv
// Shared constants for the inter-packet delay blocks (TX replay and RX recorder).
// Keeping the delay field position and width here stops the two sides drifting apart.
package osnt_ipd_pkg;

  // Width of the delay field carried in tuser and of the gap counter.
  localparam int DELAY_WIDTH = 32;

  // LSB of the delay field inside tuser.
  localparam int TUSER_TIMESTAMP_POS = 32;

  // Largest representable delay; the gap counter sticks here on long idles.
  localparam logic [DELAY_WIDTH-1:0] DELAY_SAT = '1;

  typedef logic [DELAY_WIDTH-1:0] delay_t;

endpackage : osnt_ipd_pkg

// File: rtl/osnt_inter_packet_delay_recorder_gap_meter.sv
// Gap meter: counts clock cycles between start-of-packet acceptances, provides
// the delay to stamp into the current SOP and keeps last/max/count statistics.
module ipd_gap_meter
  import osnt_ipd_pkg::*;
#(
  parameter int W = DELAY_WIDTH
) (
  input  logic         clk,
  input  logic         srst,
  input  logic         sw_rst,
  input  logic         sop_accept,
  output logic [W-1:0] cap_delay,
  output logic [W-1:0] last_delay,
  output logic [W-1:0] max_delay,
  output logic [31:0]  pkt_count
);

  // All-ones of the configured width; the counter holds here instead of wrapping.
  localparam logic [W-1:0] GAP_SAT = {W{1'b1}};
  localparam logic [W-1:0] GAP_ONE = W'(1);

  logic [W-1:0] gap_cnt_reg;
  logic         first_reg;
  logic [W-1:0] last_delay_reg;
  logic [W-1:0] max_delay_reg;
  logic [31:0]  pkt_count_reg;

  // The first SOP after a reset has no predecessor, so it reports zero.
  // An SOP landing while sw_rst is held is treated the same way.
  assign cap_delay = (first_reg || sw_rst) ? '0 : gap_cnt_reg;

  // Gap counter: restarts at 1 on each SOP so the next SOP sees the cycle distance.
  always_ff @(posedge clk) begin
    if (srst || sw_rst) begin
      gap_cnt_reg <= '0;
    end else if (sop_accept) begin
      gap_cnt_reg <= GAP_ONE;
    end else if (gap_cnt_reg != GAP_SAT) begin
      gap_cnt_reg <= gap_cnt_reg + GAP_ONE;
    end
  end

  // First-packet flag: armed by any reset, consumed by the first clean SOP.
  always_ff @(posedge clk) begin
    if (srst || sw_rst) begin
      first_reg <= 1'b1;
    end else if (sop_accept) begin
      first_reg <= 1'b0;
    end
  end

  // Statistics registers: updated one cycle after each accepted SOP.
  always_ff @(posedge clk) begin
    if (srst || sw_rst) begin
      last_delay_reg <= '0;
      max_delay_reg  <= '0;
      pkt_count_reg  <= '0;
    end else if (sop_accept) begin
      last_delay_reg <= cap_delay;
      if (cap_delay > max_delay_reg) begin
        max_delay_reg <= cap_delay;
      end
      pkt_count_reg <= pkt_count_reg + 32'd1;
    end
  end

  assign last_delay = last_delay_reg;
  assign max_delay  = max_delay_reg;
  assign pkt_count  = pkt_count_reg;

endmodule : ipd_gap_meter

// File: rtl/osnt_inter_packet_delay_recorder.sv
// RX inter-packet delay recorder: a single AXI-Stream register stage that
// writes the cycle gap between consecutive SOP acceptances into the tuser delay
// field of each packet's first beat, and exports last/max delay and packet count.
module osnt_inter_packet_delay_recorder
  import osnt_ipd_pkg::*;
#(
  parameter int C_M_AXIS_DATA_WIDTH   = 512,
  parameter int C_S_AXIS_DATA_WIDTH   = 512,
  parameter int C_M_AXIS_TUSER_WIDTH  = 128,
  parameter int C_S_AXIS_TUSER_WIDTH  = 128,
  parameter int C_TUSER_TIMESTAMP_POS = TUSER_TIMESTAMP_POS,
  parameter int C_DELAY_WIDTH         = DELAY_WIDTH
) (
  input  logic                               axis_aclk,
  input  logic                               axis_reset,

  input  logic [C_S_AXIS_DATA_WIDTH-1:0]     s_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]   s_axis_tkeep,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]    s_axis_tuser,
  input  logic                               s_axis_tvalid,
  output logic                               s_axis_tready,
  input  logic                               s_axis_tlast,

  output logic [C_M_AXIS_DATA_WIDTH-1:0]     m_axis_tdata,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]   m_axis_tkeep,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]    m_axis_tuser,
  output logic                               m_axis_tvalid,
  input  logic                               m_axis_tready,
  output logic                               m_axis_tlast,

  input  logic                               sw_rst,
  input  logic                               stamp_en,
  output logic [C_DELAY_WIDTH-1:0]           last_delay,
  output logic [C_DELAY_WIDTH-1:0]           max_delay,
  output logic [31:0]                        pkt_count
);

  localparam int FIELD_LO = C_TUSER_TIMESTAMP_POS;
  localparam int FIELD_HI = C_TUSER_TIMESTAMP_POS + C_DELAY_WIDTH;

  // Output register stage.
  logic [C_M_AXIS_DATA_WIDTH-1:0]   m_tdata_reg;
  logic [C_M_AXIS_DATA_WIDTH/8-1:0] m_tkeep_reg;
  logic [C_M_AXIS_TUSER_WIDTH-1:0]  m_tuser_reg;
  logic                             m_tvalid_reg;
  logic                             m_tlast_reg;

  // Next beat is the first of a packet.
  logic                             in_sop_reg;

  logic                             s_ready_int;
  logic                             beat_accept;
  logic                             sop_accept;
  logic                             stamp_sel;
  logic [C_DELAY_WIDTH-1:0]         cap_delay;
  logic [C_S_AXIS_TUSER_WIDTH-1:0]  tuser_next;

  // The stage can take a beat whenever it is empty or draining this cycle,
  // which gives full throughput with no bubbles on back-to-back beats.
  assign s_ready_int   = !m_tvalid_reg || m_axis_tready;
  assign s_axis_tready = s_ready_int;
  assign beat_accept   = s_axis_tvalid && s_ready_int;
  assign sop_accept    = beat_accept && in_sop_reg;

  // stamp_en only matters on the SOP beat; later beats always pass tuser as is.
  assign stamp_sel     = in_sop_reg && stamp_en;

  ipd_gap_meter #(
    .W(C_DELAY_WIDTH)
  ) u_gap_meter (
    .clk        (axis_aclk),
    .srst       (axis_reset),
    .sw_rst     (sw_rst),
    .sop_accept (sop_accept),
    .cap_delay  (cap_delay),
    .last_delay (last_delay),
    .max_delay  (max_delay),
    .pkt_count  (pkt_count)
  );

  // tuser merge: bits inside the delay field take the captured delay on a
  // stamped SOP beat; every other bit is copied straight through.
  generate
    for (genvar gi = 0; gi < C_S_AXIS_TUSER_WIDTH; gi++) begin : g_tuser_merge
      if (gi >= FIELD_LO && gi < FIELD_HI) begin : g_field
        assign tuser_next[gi] = stamp_sel ? cap_delay[gi - FIELD_LO] : s_axis_tuser[gi];
      end else begin : g_pass
        assign tuser_next[gi] = s_axis_tuser[gi];
      end
    end
  endgenerate

  // Packet framing tracker: the beat after a tlast starts a new packet.
  always_ff @(posedge axis_aclk) begin
    if (axis_reset) begin
      in_sop_reg <= 1'b1;
    end else if (beat_accept) begin
      in_sop_reg <= s_axis_tlast;
    end
  end

  // Output register: loads on acceptance, holds while stalled, empties on drain.
  always_ff @(posedge axis_aclk) begin
    if (axis_reset) begin
      m_tvalid_reg <= 1'b0;
      m_tdata_reg  <= '0;
      m_tkeep_reg  <= '0;
      m_tuser_reg  <= '0;
      m_tlast_reg  <= 1'b0;
    end else if (s_ready_int) begin
      m_tvalid_reg <= s_axis_tvalid;
      if (s_axis_tvalid) begin
        m_tdata_reg <= s_axis_tdata;
        m_tkeep_reg <= s_axis_tkeep;
        m_tuser_reg <= tuser_next;
        m_tlast_reg <= s_axis_tlast;
      end
    end
  end

  assign m_axis_tdata  = m_tdata_reg;
  assign m_axis_tkeep  = m_tkeep_reg;
  assign m_axis_tuser  = m_tuser_reg;
  assign m_axis_tvalid = m_tvalid_reg;
  assign m_axis_tlast  = m_tlast_reg;

endmodule : osnt_inter_packet_delay_recorder

// File: tb/tb_osnt_inter_packet_delay_recorder.sv
// Bench for osnt_inter_packet_delay_recorder: a 32-bit and an 8-bit delay
// instance share one stimulus stream; a queue-based reference model derives
// stamped beats and statistics from SOP acceptance cycle numbers.
module tb_osnt_inter_packet_delay_recorder;

  localparam int DW  = 64;
  localparam int TUW = 128;
  localparam int POS = 32;
  localparam logic [TUW-1:0] PAT_A5 = {4{32'hA5A5A5A5}};

  logic           clk = 1'b0;
  logic           rst;
  logic [DW-1:0]  s_tdata;
  logic [DW/8-1:0] s_tkeep;
  logic [TUW-1:0] s_tuser;
  logic           s_tvalid, s_tlast, m_tready, sw_rst, stamp_en;

  logic [DW-1:0]  a_tdata, b_tdata;
  logic [DW/8-1:0] a_tkeep, b_tkeep;
  logic [TUW-1:0] a_tuser, b_tuser;
  logic           a_tvalid, b_tvalid, a_tlast, b_tlast, a_tready, b_tready;
  logic [31:0]    a_last, a_max, a_cnt, b_cnt;
  logic [7:0]     b_last, b_max;

  always #5 clk = ~clk;

  osnt_inter_packet_delay_recorder #(
    .C_M_AXIS_DATA_WIDTH(DW), .C_S_AXIS_DATA_WIDTH(DW),
    .C_M_AXIS_TUSER_WIDTH(TUW), .C_S_AXIS_TUSER_WIDTH(TUW),
    .C_TUSER_TIMESTAMP_POS(POS), .C_DELAY_WIDTH(32)
  ) dut_a (
    .axis_aclk(clk), .axis_reset(rst),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tuser(s_tuser),
    .s_axis_tvalid(s_tvalid), .s_axis_tready(a_tready), .s_axis_tlast(s_tlast),
    .m_axis_tdata(a_tdata), .m_axis_tkeep(a_tkeep), .m_axis_tuser(a_tuser),
    .m_axis_tvalid(a_tvalid), .m_axis_tready(m_tready), .m_axis_tlast(a_tlast),
    .sw_rst(sw_rst), .stamp_en(stamp_en),
    .last_delay(a_last), .max_delay(a_max), .pkt_count(a_cnt)
  );

  osnt_inter_packet_delay_recorder #(
    .C_M_AXIS_DATA_WIDTH(DW), .C_S_AXIS_DATA_WIDTH(DW),
    .C_M_AXIS_TUSER_WIDTH(TUW), .C_S_AXIS_TUSER_WIDTH(TUW),
    .C_TUSER_TIMESTAMP_POS(POS), .C_DELAY_WIDTH(8)
  ) dut_b (
    .axis_aclk(clk), .axis_reset(rst),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tuser(s_tuser),
    .s_axis_tvalid(s_tvalid), .s_axis_tready(b_tready), .s_axis_tlast(s_tlast),
    .m_axis_tdata(b_tdata), .m_axis_tkeep(b_tkeep), .m_axis_tuser(b_tuser),
    .m_axis_tvalid(b_tvalid), .m_axis_tready(m_tready), .m_axis_tlast(b_tlast),
    .sw_rst(sw_rst), .stamp_en(stamp_en),
    .last_delay(b_last), .max_delay(b_max), .pkt_count(b_cnt)
  );

  typedef struct {
    logic [DW-1:0]   data;
    logic [DW/8-1:0] keep;
    logic [TUW-1:0]  user_a;
    logic [TUW-1:0]  user_b;
    logic            last;
    bit              sop;
  } beat_t;

  typedef struct {
    int          gap;
    int          nbeats;
    bit          en;
    logic [31:0] exp_a;
    logic [7:0]  exp_b;
    logic [31:0] exp_last;
    logic [31:0] exp_max;
    logic [31:0] exp_cnt;
  } vec_t;

  beat_t       exp_q[$];
  int          n_vec = 0;
  int          n_bad = 0;
  int          cyc = 0;
  bit          last_acc = 1'b0;

  // Reference model state
  bit          m_in_sop, m_first;
  int          m_last_sop_cyc;
  logic [31:0] m_last_a, m_max_a, m_cnt;
  logic [7:0]  m_last_b, m_max_b;
  logic [31:0] seen_a;
  logic [7:0]  seen_b;

  task automatic chk(input string name, input logic [TUW-1:0] act, input logic [TUW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %h want %h", name, cyc, act, exp);
    end
  endtask

  // One clock: check outputs at the falling edge, advance the model, then step past the rising edge.
  task automatic tick();
    bit          exp_tready;
    beat_t       eb;
    int          gap;
    logic [31:0] d32;
    logic [7:0]  d8;
    @(negedge clk);
    last_acc = 1'b0;
    if (!rst) begin
      exp_tready = (exp_q.size() == 0) || m_tready;
      chk("a_tvalid", TUW'(a_tvalid), TUW'(exp_q.size() != 0));
      chk("b_tvalid", TUW'(b_tvalid), TUW'(exp_q.size() != 0));
      chk("a_tready", TUW'(a_tready), TUW'(exp_tready));
      chk("b_tready", TUW'(b_tready), TUW'(exp_tready));
      chk("a_last_delay", TUW'(a_last), TUW'(m_last_a));
      chk("a_max_delay", TUW'(a_max), TUW'(m_max_a));
      chk("a_pkt_count", TUW'(a_cnt), TUW'(m_cnt));
      chk("b_last_delay", TUW'(b_last), TUW'(m_last_b));
      chk("b_max_delay", TUW'(b_max), TUW'(m_max_b));
      chk("b_pkt_count", TUW'(b_cnt), TUW'(m_cnt));
      if (exp_q.size() != 0 && m_tready) begin
        eb = exp_q.pop_front();
        chk("a_tdata", TUW'(a_tdata), TUW'(eb.data));
        chk("a_tkeep", TUW'(a_tkeep), TUW'(eb.keep));
        chk("a_tuser", a_tuser, eb.user_a);
        chk("a_tlast", TUW'(a_tlast), TUW'(eb.last));
        chk("b_tdata", TUW'(b_tdata), TUW'(eb.data));
        chk("b_tuser", b_tuser, eb.user_b);
        chk("b_tlast", TUW'(b_tlast), TUW'(eb.last));
        if (eb.sop) begin
          seen_a = a_tuser[POS +: 32];
          seen_b = b_tuser[POS +: 8];
        end
      end
      last_acc = s_tvalid && exp_tready;
      if (last_acc) begin
        eb.data   = s_tdata;
        eb.keep   = s_tkeep;
        eb.user_a = s_tuser;
        eb.user_b = s_tuser;
        eb.last   = s_tlast;
        eb.sop    = m_in_sop;
        if (m_in_sop) begin
          // Acceptance happens at the coming rising edge, numbered cyc+1.
          gap = (cyc + 1) - m_last_sop_cyc;
          if (sw_rst || m_first) begin
            d32 = '0;
            d8  = '0;
          end else begin
            d32 = 32'(gap);
            d8  = (gap > 255) ? 8'hFF : 8'(gap);
          end
          if (stamp_en) begin
            eb.user_a[POS +: 32] = d32;
            eb.user_b[POS +: 8]  = d8;
          end
          m_last_sop_cyc = cyc + 1;
          if (!sw_rst) begin
            m_first  = 1'b0;
            m_last_a = d32;
            m_last_b = d8;
            if (d32 > m_max_a) m_max_a = d32;
            if (d8 > m_max_b)  m_max_b = d8;
            m_cnt = m_cnt + 32'd1;
          end
        end
        m_in_sop = s_tlast;
        exp_q.push_back(eb);
      end
      if (sw_rst) begin
        m_first  = 1'b1;
        m_last_a = '0;
        m_max_a  = '0;
        m_last_b = '0;
        m_max_b  = '0;
        m_cnt    = '0;
      end
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic send_beat(input logic [TUW-1:0] user, input bit last, input bit en);
    int guard;
    s_tvalid = 1'b1;
    s_tdata  = {$urandom, $urandom};
    s_tkeep  = 8'($urandom);
    s_tuser  = user;
    s_tlast  = last;
    stamp_en = en;
    guard    = 0;
    do begin
      tick();
      guard++;
    end while (!last_acc && guard < 100);
    if (!last_acc) chk("accept_timeout", TUW'(0), TUW'(1));
    s_tvalid = 1'b0;
  endtask

  task automatic send_pkt(input int n, input bit en);
    for (int i = 0; i < n; i++) send_beat(PAT_A5, (i == n - 1), en);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cyc %0d", cyc);
    $fatal(1);
  end

  initial begin
    vec_t tbl[8];
    int   prev_sop;
    int   sent, k;

    tbl[0] = '{0,   1, 1'b1, 32'd0,        8'd0,    32'd0,   32'd0,   32'd1};
    tbl[1] = '{15,  1, 1'b1, 32'd15,       8'd15,   32'd15,  32'd15,  32'd2};
    tbl[2] = '{100, 1, 1'b1, 32'd100,      8'd100,  32'd100, 32'd100, 32'd3};
    tbl[3] = '{20,  4, 1'b1, 32'd20,       8'd20,   32'd20,  32'd100, 32'd4};
    tbl[4] = '{6,   1, 1'b1, 32'd6,        8'd6,    32'd6,   32'd100, 32'd5};
    tbl[5] = '{300, 1, 1'b1, 32'd300,      8'd255,  32'd300, 32'd300, 32'd6};
    tbl[6] = '{4,   1, 1'b1, 32'd4,        8'd4,    32'd4,   32'd300, 32'd7};
    tbl[7] = '{7,   1, 1'b0, 32'hA5A5A5A5, 8'hA5,   32'd7,   32'd300, 32'd8};

    rst = 1'b1; s_tdata = '0; s_tkeep = '0; s_tuser = '0; s_tvalid = 1'b0;
    s_tlast = 1'b0; m_tready = 1'b1; sw_rst = 1'b0; stamp_en = 1'b1;
    m_in_sop = 1'b1; m_first = 1'b1; m_last_sop_cyc = 0;
    m_last_a = '0; m_max_a = '0; m_cnt = '0; m_last_b = '0; m_max_b = '0;
    seen_a = '0; seen_b = '0;
    repeat (3) tick();
    rst = 1'b0;

    // Reset state
    chk("rst_tvalid", TUW'(a_tvalid), TUW'(0));
    chk("rst_tready", TUW'(a_tready), TUW'(1));
    chk("rst_pkt_count", TUW'(a_cnt), TUW'(0));
    chk("rst_max_delay", TUW'(a_max), TUW'(0));
    chk("rst_tuser", a_tuser, TUW'(0));
    repeat (5) tick();

    // Directed table: SOP spacing, multi-beat packets, saturation, passthrough
    prev_sop = 0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) while (cyc + 1 < prev_sop + tbl[i].gap) tick();
      prev_sop = cyc + 1;
      send_pkt(tbl[i].nbeats, tbl[i].en);
      tick();
      tick();
      chk($sformatf("tbl%0d_stamp_a", i), TUW'(seen_a), TUW'(tbl[i].exp_a));
      chk($sformatf("tbl%0d_stamp_b", i), TUW'(seen_b), TUW'(tbl[i].exp_b));
      chk($sformatf("tbl%0d_last", i), TUW'(a_last), TUW'(tbl[i].exp_last));
      chk($sformatf("tbl%0d_max", i), TUW'(a_max), TUW'(tbl[i].exp_max));
      chk($sformatf("tbl%0d_count", i), TUW'(a_cnt), TUW'(tbl[i].exp_cnt));
    end
    chk("b_max_saturated", TUW'(b_max), TUW'(8'd255));
    chk("b_last_final", TUW'(b_last), TUW'(8'd7));

    // Downstream stall for 5 cycles while the source streams 2-beat packets
    sent = 0; k = 0;
    s_tvalid = 1'b1; s_tdata = {$urandom, $urandom}; s_tkeep = '1;
    s_tuser = PAT_A5; s_tlast = 1'b0; stamp_en = 1'b1;
    while (sent < 8 && k < 100) begin
      m_tready = !(k >= 2 && k < 7);
      tick();
      k++;
      if (last_acc) begin
        sent++;
        s_tdata = {$urandom, $urandom};
        s_tlast = sent[0];
      end
    end
    if (sent < 8) chk("stall_timeout", TUW'(sent), TUW'(8));
    s_tvalid = 1'b0; m_tready = 1'b1;
    repeat (3) tick();

    // sw_rst pulse in the middle of a 3-beat packet
    send_beat(PAT_A5, 1'b0, 1'b1);
    sw_rst = 1'b1;
    send_beat(PAT_A5, 1'b0, 1'b1);
    sw_rst = 1'b0;
    send_beat(PAT_A5, 1'b1, 1'b1);
    repeat (5) tick();
    send_pkt(1, 1'b1);
    tick();
    tick();
    chk("swrst_stamp", TUW'(seen_a), TUW'(0));
    chk("swrst_count", TUW'(a_cnt), TUW'(1));
    chk("swrst_max", TUW'(a_max), TUW'(0));

    // Randomized traffic with backpressure, stamp_en toggling and sw_rst pulses
    last_acc = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if (!s_tvalid || last_acc) begin
        s_tvalid = ($urandom_range(0, 2) != 0);
        s_tdata  = {$urandom, $urandom};
        s_tkeep  = 8'($urandom);
        s_tuser  = {$urandom, $urandom, $urandom, $urandom};
        s_tlast  = ($urandom_range(0, 2) == 0);
      end
      m_tready = ($urandom_range(0, 3) != 0);
      stamp_en = 1'($urandom_range(0, 1));
      sw_rst   = ($urandom_range(0, 199) == 0);
      tick();
    end
    s_tvalid = 1'b0; m_tready = 1'b1; sw_rst = 1'b0;
    repeat (3) tick();
    chk("drain_empty", TUW'(exp_q.size()), TUW'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule : tb_osnt_inter_packet_delay_recorder
